// File: rtl/sram_fault_responder_if.sv
// Bus between the MBIST controller (master) and the SRAM responder (slave).
interface sram_fault_responder_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] iAddr;
  logic              iWrite;
  logic [DATA_W-1:0] iWrData;
  logic              iRead;
  logic [DATA_W-1:0] oRdData;
  logic              oRdValid;

  modport master (
    output iAddr, iWrite, iWrData, iRead,
    input  oRdData, oRdValid
  );

  modport slave (
    input  iAddr, iWrite, iWrData, iRead,
    output oRdData, oRdValid
  );
endinterface

// File: rtl/sram_fault_responder.sv
// Single-port SRAM responder for MBIST with one programmable injected fault
// (stuck-at, up-transition or idempotent coupling) and an activation counter.
module sram_fault_responder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  sram_fault_responder_if.slave bus,
  input  logic                  FAULT_LOAD,
  input  logic                  FAULT_EN,
  input  logic [1:0]            FAULT_TYPE,
  input  logic [ADDR_W-1:0]     FAULT_ADDR,
  input  logic [2:0]            FAULT_BIT,
  input  logic [ADDR_W-1:0]     FAULT_AGGR,
  output logic [CNT_W-1:0]      oFaultCnt
);

  localparam int unsigned BIT_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    FT_SA0   = 2'b00,
    FT_SA1   = 2'b01,
    FT_TF_UP = 2'b10,
    FT_CF    = 2'b11
  } fault_type_e;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              cfg_en;
  fault_type_e       cfg_type;
  logic [ADDR_W-1:0] cfg_addr;
  logic [BIT_W-1:0]  cfg_bit;
  logic [ADDR_W-1:0] cfg_aggr;

  logic [DATA_W-1:0] old_word_c;
  logic [DATA_W-1:0] rd_word_c;
  logic [DATA_W-1:0] wr_word_c;
  logic              victim_set_c;
  logic              activate_c;
  logic              stuck_c;

  // Fault effects on the read word, the stored word and the coupled victim.
  always_comb begin
    old_word_c   = mem[bus.iAddr];
    rd_word_c    = old_word_c;
    wr_word_c    = bus.iWrData;
    victim_set_c = 1'b0;
    activate_c   = 1'b0;
    stuck_c      = (cfg_type == FT_SA1);
    if (cfg_en) begin
      case (cfg_type)
        FT_SA0, FT_SA1: begin
          if (bus.iAddr == cfg_addr) begin
            rd_word_c[cfg_bit] = stuck_c;
            wr_word_c[cfg_bit] = stuck_c;
            activate_c = bus.iWrite && (bus.iWrData[cfg_bit] != stuck_c);
          end
        end
        FT_TF_UP: begin
          if (bus.iWrite && (bus.iAddr == cfg_addr) &&
              bus.iWrData[cfg_bit] && !old_word_c[cfg_bit]) begin
            wr_word_c[cfg_bit] = 1'b0;
            activate_c = 1'b1;
          end
        end
        FT_CF: begin
          // Self-coupling (aggressor == victim word) is meaningless and ignored.
          if (bus.iWrite && (bus.iAddr == cfg_aggr) && (cfg_aggr != cfg_addr) &&
              !old_word_c[cfg_bit] && bus.iWrData[cfg_bit]) begin
            victim_set_c = 1'b1;
            activate_c   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Array storage; a coupling event sets the victim bit alongside the write.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (bus.iWrite) begin
        mem[bus.iAddr] <= wr_word_c;
      end
      if (victim_set_c) begin
        mem[cfg_addr][cfg_bit] <= 1'b1;
      end
    end
  end

  // Registered read port, read-before-write against a same-cycle write.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      bus.oRdData  <= '0;
      bus.oRdValid <= 1'b0;
    end else begin
      bus.oRdValid <= bus.iRead;
      if (bus.iRead) begin
        bus.oRdData <= rd_word_c;
      end
    end
  end

  // Fault configuration latch; takes effect from the following cycle.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      cfg_en   <= 1'b0;
      cfg_type <= FT_SA0;
      cfg_addr <= '0;
      cfg_bit  <= '0;
      cfg_aggr <= '0;
    end else if (FAULT_LOAD) begin
      cfg_en   <= FAULT_EN;
      cfg_type <= fault_type_e'(FAULT_TYPE);
      cfg_addr <= FAULT_ADDR;
      cfg_bit  <= FAULT_BIT;
      cfg_aggr <= FAULT_AGGR;
    end
  end

  // Saturating fault-activation counter.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      oFaultCnt <= '0;
    end else if (activate_c && (oFaultCnt != CNT_MAX)) begin
      oFaultCnt <= oFaultCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sram_fault_responder.sv
// Directed bench for sram_fault_responder with a word-level reference model.
module tb_sram_fault_responder;

  logic       CLK;
  logic       nRESET;
  logic       FAULT_LOAD;
  logic       FAULT_EN;
  logic [1:0] FAULT_TYPE;
  logic [7:0] FAULT_ADDR;
  logic [2:0] FAULT_BIT;
  logic [7:0] FAULT_AGGR;
  logic [7:0] oFaultCnt;

  sram_fault_responder_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  sram_fault_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .CNT_W(8)) dut (
    .CLK        (CLK),
    .nRESET     (nRESET),
    .bus        (bus),
    .FAULT_LOAD (FAULT_LOAD),
    .FAULT_EN   (FAULT_EN),
    .FAULT_TYPE (FAULT_TYPE),
    .FAULT_ADDR (FAULT_ADDR),
    .FAULT_BIT  (FAULT_BIT),
    .FAULT_AGGR (FAULT_AGGR),
    .oFaultCnt  (oFaultCnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] rd;
    logic [7:0] store;
    logic       vset;
    logic       act;
  } step_t;

  logic [7:0] m_mem [256];
  logic       c_en;
  logic [1:0] c_ty;
  logic [7:0] c_addr;
  logic [2:0] c_bit;
  logic [7:0] c_aggr;
  logic [7:0] exp_data;
  logic       exp_valid;
  logic [7:0] exp_cnt;

  // What one bus cycle does under the active fault, expressed with bit masks.
  function automatic step_t model_step(input logic [7:0] cur, a, d, input logic wr,
                                       input logic en, input logic [1:0] ty,
                                       input logic [7:0] fa, input logic [2:0] fb,
                                       input logic [7:0] ag);
    step_t s;
    logic [7:0] mask;
    mask    = 8'(1) << fb;
    s.rd    = cur;
    s.store = d;
    s.vset  = 1'b0;
    s.act   = 1'b0;
    if (en) begin
      if (ty == 2'b00 || ty == 2'b01) begin
        if (a == fa) begin
          s.rd    = ty[0] ? (cur | mask) : (cur & ~mask);
          s.store = ty[0] ? (d | mask) : (d & ~mask);
          s.act   = wr && (((d & mask) != 8'h00) != ty[0]);
        end
      end else if (ty == 2'b10) begin
        if (wr && a == fa && (d & mask) != 8'h00 && (cur & mask) == 8'h00) begin
          s.store = d & ~mask;
          s.act   = 1'b1;
        end
      end else begin
        if (wr && a == ag && ag != fa && (~cur & d & mask) != 8'h00) begin
          s.vset = 1'b1;
          s.act  = 1'b1;
        end
      end
    end
    return s;
  endfunction

  step_t s_c;
  assign s_c = model_step(m_mem[bus.iAddr], bus.iAddr, bus.iWrData, bus.iWrite,
                          c_en, c_ty, c_addr, c_bit, c_aggr);

  // Model state update, mirrors the bus cycle at each rising edge.
  always @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < 256; i++) m_mem[i] <= 8'h00;
      c_en <= 1'b0; c_ty <= 2'b00; c_addr <= 8'h00; c_bit <= 3'd0; c_aggr <= 8'h00;
      exp_data <= 8'h00; exp_valid <= 1'b0; exp_cnt <= 8'h00;
    end else begin
      if (FAULT_LOAD) begin
        c_en <= FAULT_EN; c_ty <= FAULT_TYPE; c_addr <= FAULT_ADDR;
        c_bit <= FAULT_BIT; c_aggr <= FAULT_AGGR;
      end
      if (bus.iWrite) m_mem[bus.iAddr] <= s_c.store;
      if (s_c.vset) m_mem[c_addr][c_bit] <= 1'b1;
      exp_valid <= bus.iRead;
      if (bus.iRead) exp_data <= s_c.rd;
      if (s_c.act && exp_cnt != 8'hFF) exp_cnt <= exp_cnt + 8'd1;
    end
  end

  // ---------------- checking ----------------
  int    n_chk = 0;
  int    n_err = 0;
  bit    chk_on = 1'b0;
  string pin_name = "";
  logic       pin_v;
  logic [7:0] pin_d;
  logic [7:0] pin_c;
  int    pin_seq = 0;
  int    pin_seen = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle: DUT against model; plus any hand-computed expectation posted.
  always @(posedge CLK) begin
    #2;
    if (chk_on) begin
      check("rd_valid", 32'(bus.oRdValid), 32'(exp_valid));
      check("rd_data", 32'(bus.oRdData), 32'(exp_data));
      check("fault_cnt", 32'(oFaultCnt), 32'(exp_cnt));
      if (pin_seq != pin_seen) begin
        pin_seen = pin_seq;
        check({pin_name, "_valid"}, 32'(bus.oRdValid), 32'(pin_v));
        check({pin_name, "_data"}, 32'(bus.oRdData), 32'(pin_d));
        check({pin_name, "_cnt"}, 32'(oFaultCnt), 32'(pin_c));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pin(input string nm, input logic v, input logic [7:0] d, input logic [7:0] c);
    pin_name = nm; pin_v = v; pin_d = d; pin_c = c;
    pin_seq++;
  endtask

  task automatic bus_op(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    bus.iRead = rd; bus.iWrite = wr; bus.iAddr = a; bus.iWrData = d;
    FAULT_LOAD = 1'b0;
    @(posedge CLK);
  endtask

  task automatic load(input logic en, input logic [1:0] ty, input logic [7:0] fa,
                      input logic [2:0] fb, input logic [7:0] ag);
    @(negedge CLK);
    bus.iRead = 1'b0; bus.iWrite = 1'b0;
    FAULT_LOAD = 1'b1; FAULT_EN = en; FAULT_TYPE = ty;
    FAULT_ADDR = fa; FAULT_BIT = fb; FAULT_AGGR = ag;
    @(posedge CLK);
  endtask

  initial begin
    nRESET = 1'b1;
    bus.iRead = 1'b0; bus.iWrite = 1'b0; bus.iAddr = 8'h00; bus.iWrData = 8'h00;
    FAULT_LOAD = 1'b0; FAULT_EN = 1'b0; FAULT_TYPE = 2'b00;
    FAULT_ADDR = 8'h00; FAULT_BIT = 3'd0; FAULT_AGGR = 8'h00;
    #1 nRESET = 1'b0;
    chk_on = 1'b1;
    repeat (2) @(posedge CLK);
    pin("reset", 1'b0, 8'h00, 8'h00);
    @(negedge CLK);
    nRESET = 1'b1;

    // Basic write / read and hold
    bus_op(1'b0, 1'b1, 8'h10, 8'hA5);
    bus_op(1'b1, 1'b0, 8'h10, 8'h00);
    pin("rd_a5", 1'b1, 8'hA5, 8'h00);
    bus_op(1'b0, 1'b0, 8'h00, 8'h00);
    pin("hold_a5", 1'b0, 8'hA5, 8'h00);

    // Fill with data = address, read everything back, then wrap FF -> 00
    for (int i = 0; i < 256; i++) bus_op(1'b0, 1'b1, 8'(i), 8'(i));
    for (int i = 0; i < 256; i++) bus_op(1'b1, 1'b0, 8'(i), 8'h00);
    pin("rd_ff", 1'b1, 8'hFF, 8'h00);
    bus_op(1'b1, 1'b0, 8'h00, 8'h00);
    pin("wrap_00", 1'b1, 8'h00, 8'h00);

    // SA0 at 0x20 bit 3
    load(1'b1, 2'b00, 8'h20, 3'd3, 8'h00);
    bus_op(1'b0, 1'b1, 8'h20, 8'hFF);
    bus_op(1'b1, 1'b0, 8'h20, 8'h00);
    pin("sa0_rd", 1'b1, 8'hF7, 8'h01);
    bus_op(1'b0, 1'b1, 8'h20, 8'h00);
    bus_op(1'b1, 1'b0, 8'h20, 8'h00);
    pin("sa0_no_inc", 1'b1, 8'h00, 8'h01);

    // TF-up at 0x05 bit 0
    load(1'b1, 2'b10, 8'h05, 3'd0, 8'h00);
    bus_op(1'b0, 1'b1, 8'h05, 8'h00);
    bus_op(1'b0, 1'b1, 8'h05, 8'h01);
    bus_op(1'b1, 1'b0, 8'h05, 8'h00);
    pin("tf_rd", 1'b1, 8'h00, 8'h02);
    bus_op(1'b0, 1'b1, 8'h05, 8'h00);
    bus_op(1'b1, 1'b0, 8'h05, 8'h00);
    pin("tf_hold", 1'b1, 8'h00, 8'h02);

    // CF: aggressor 0x40, victim 0x41, bit 7
    load(1'b1, 2'b11, 8'h41, 3'd7, 8'h40);
    bus_op(1'b0, 1'b1, 8'h40, 8'h00);
    bus_op(1'b0, 1'b1, 8'h41, 8'h00);
    bus_op(1'b0, 1'b1, 8'h40, 8'h80);
    bus_op(1'b1, 1'b0, 8'h41, 8'h00);
    pin("cf_victim", 1'b1, 8'h80, 8'h03);

    // CF with aggressor == victim word is ignored
    load(1'b1, 2'b11, 8'h50, 3'd0, 8'h50);
    bus_op(1'b0, 1'b1, 8'h50, 8'h00);
    bus_op(1'b0, 1'b1, 8'h50, 8'h01);
    bus_op(1'b1, 1'b0, 8'h50, 8'h00);
    pin("cf_self", 1'b1, 8'h01, 8'h03);

    // Simultaneous read and write: read-before-write
    bus_op(1'b0, 1'b1, 8'h30, 8'h11);
    bus_op(1'b1, 1'b1, 8'h30, 8'h22);
    pin("rbw_old", 1'b1, 8'h11, 8'h03);
    bus_op(1'b1, 1'b0, 8'h30, 8'h00);
    pin("rbw_new", 1'b1, 8'h22, 8'h03);

    // SA1 forces the read even without a write, then on write
    load(1'b1, 2'b01, 8'h60, 3'd2, 8'h00);
    bus_op(1'b1, 1'b0, 8'h60, 8'h00);
    pin("sa1_rd", 1'b1, 8'h64, 8'h03);
    bus_op(1'b0, 1'b1, 8'h60, 8'h00);
    bus_op(1'b1, 1'b0, 8'h60, 8'h00);
    pin("sa1_wr", 1'b1, 8'h04, 8'h04);

    // Counter saturation
    load(1'b1, 2'b00, 8'h70, 3'd0, 8'h00);
    repeat (260) bus_op(1'b0, 1'b1, 8'h70, 8'hFF);
    bus_op(1'b1, 1'b0, 8'h70, 8'h00);
    pin("sat", 1'b1, 8'hFE, 8'hFF);

    // Reset in the middle of a read with a CF fault armed
    load(1'b1, 2'b11, 8'h41, 3'd7, 8'h40);
    @(negedge CLK);
    bus.iRead = 1'b1; bus.iWrite = 1'b0; bus.iAddr = 8'h30; FAULT_LOAD = 1'b0;
    #1 nRESET = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    nRESET = 1'b1;
    bus.iRead = 1'b0;
    @(posedge CLK);
    pin("rst_mid", 1'b0, 8'h00, 8'h00);
    bus_op(1'b1, 1'b0, 8'h30, 8'h00);
    pin("rst_arr", 1'b1, 8'h00, 8'h00);
    bus_op(1'b0, 1'b1, 8'h41, 8'h00);
    bus_op(1'b0, 1'b1, 8'h40, 8'h80);
    bus_op(1'b1, 1'b0, 8'h41, 8'h00);
    pin("rst_nofault", 1'b1, 8'h00, 8'h00);
    bus_op(1'b0, 1'b0, 8'h00, 8'h00);
    bus_op(1'b0, 1'b0, 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
